// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache. Hits complete combinationally;
// misses stall the core through an optional dirty writeback then a line fill.
module dcache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4   // power of 2, at least 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS = 32 - OFF_BITS - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t                state_q, state_d;
  logic [OFF_BITS-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]      valid_q, valid_d, dirty_q, dirty_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;

  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES][LINE_WORDS];

  logic [OFF_BITS-1:0]   off;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  req, hit, last;
  logic                  data_we, tag_we;
  logic [INDEX_BITS-1:0] data_widx_line;
  logic [OFF_BITS-1:0]   data_widx;
  logic [31:0]           data_wval;
  logic                  unused_addr_lsb;

  assign off  = cpu_addr[OFF_BITS+1:2];
  assign idx  = cpu_addr[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
  assign tag  = cpu_addr[31:OFF_BITS+INDEX_BITS+2];
  assign req  = cpu_rd | cpu_wr;
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign last = (cnt_q == OFF_BITS'(LINE_WORDS - 1));
  assign unused_addr_lsb = ^cpu_addr[1:0];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    miss_idx_d     = miss_idx_q;
    miss_tag_d     = miss_tag_q;
    cpu_rdata      = '0;
    cpu_stall      = (state_q != IDLE);
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    data_we        = 1'b0;
    tag_we         = 1'b0;
    data_widx_line = idx;
    data_widx      = off;
    data_wval      = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (cpu_wr) begin
              data_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end else begin
              cpu_rdata = data_q[idx][off];
            end
          end else begin
            // Latch the missing line so the burst survives a dropped request.
            cpu_stall  = 1'b1;
            cnt_d      = '0;
            miss_idx_d = idx;
            miss_tag_d = tag;
            state_d    = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
          end
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[miss_idx_q], miss_idx_q, cnt_q, 2'b00};
        mem_wdata = data_q[miss_idx_q][cnt_q];
        if (mem_ack) begin
          cnt_d = cnt_q + OFF_BITS'(1);
          if (last) begin
            cnt_d               = '0;
            dirty_d[miss_idx_q] = 1'b0;
            state_d             = FILL;
          end
        end
      end
      FILL: begin
        mem_req        = 1'b1;
        mem_addr       = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
        data_widx_line = miss_idx_q;
        data_widx      = cnt_q;
        data_wval      = mem_rdata;
        if (mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + OFF_BITS'(1);
          if (last) begin
            tag_we              = 1'b1;
            valid_d[miss_idx_q] = 1'b1;
            dirty_d[miss_idx_q] = 1'b0;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Line storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_widx_line][data_widx] <= data_wval;
    if (tag_we)  tag_q[miss_idx_q] <= miss_tag_q;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a memory responder with a scoreboard of expected
// memory word accesses, plus checks on load data and stall length per access.
module tb_dcache_ctrl;
  logic        clk, rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  op_t         exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          delay   = 0;
  int          acks    = 0;
  int          wcnt    = 0;
  logic [31:0] cap_addr, cap_wdata;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
    op_t o;
    o.we = we; o.addr = a; o.wdata = wd;
    exp_q.push_back(o);
  endtask

  // Memory responder: acks each word after `delay` idle cycles of mem_req.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_req) begin
      if (wcnt == 0) begin
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
      end
      if (wcnt == delay) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        acks++;
        chk("addr_hold", mem_addr, cap_addr);
        chk("wdata_hold", mem_wdata, cap_wdata);
        if (exp_q.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
        end else begin
          op_t o;
          o = exp_q.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, o.we});
          chk("mem_addr", mem_addr, o.addr);
          if (o.we) chk("mem_wdata", mem_wdata, o.wdata);
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = rd_mem(mem_addr);
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int exp_stall, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    #1;
    while (cpu_stall && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_mem_req_idle"}, {31'd0, mem_req}, 32'd0);
    if (rd && !wr) chk({tag, "_rdata"}, cpu_rdata, exp_rd);
    @(posedge clk);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    chk({tag, "_pending_ops"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_line(input logic we, input logic [31:0] base);
    for (int i = 0; i < 4; i++) push_op(we, base + 32'(4 * i), rd_mem(base + 32'(4 * i)));
  endtask

  initial begin
    int a0;
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      mem[32'h500 + 32'(4 * i)] = 32'hB0 + 32'(i);
      mem[32'h900 + 32'(4 * i)] = 32'hC0 + 32'(i);
    end
    #2;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Cold miss, single-cycle acks
    push_line(1'b0, 32'h100);
    access(1'b1, 1'b0, 32'h100, '0, 32'hA0, 5, "t1_cold");

    // Store hit then load hit
    access(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, '0, 0, "t2_store");
    access(1'b1, 1'b0, 32'h104, '0, 32'hDEAD_BEEF, 0, "t2_load");

    // Conflict miss on a dirty line: writeback then fill
    push_op(1'b1, 32'h100, 32'hA0);
    push_op(1'b1, 32'h104, 32'hDEAD_BEEF);
    push_op(1'b1, 32'h108, 32'hA2);
    push_op(1'b1, 32'h10C, 32'hA3);
    push_line(1'b0, 32'h500);
    access(1'b1, 1'b0, 32'h500, '0, 32'hB0, 9, "t3_evict");
    access(1'b1, 1'b0, 32'h50C, '0, 32'hB3, 0, "t3_hit");
    chk("t3_mem_104", rd_mem(32'h104), 32'hDEAD_BEEF);

    // Slow memory: three wait cycles per word
    delay = 3;
    push_line(1'b0, 32'h900);
    access(1'b1, 1'b0, 32'h904, '0, 32'hC1, 17, "t4_slow");

    // Reset during the second fill word
    push_line(1'b0, 32'h100);
    a0 = acks;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h100;
    for (int i = 0; i < 100 && acks == a0; i++) @(posedge clk);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t5_acks_before_rst", 32'(acks - a0), 32'd1);
    cpu_rd = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    delay = 0;
    push_line(1'b0, 32'h100);
    access(1'b1, 1'b0, 32'h100, '0, 32'hA0, 5, "t5_reload");
    push_line(1'b0, 32'h900);
    access(1'b1, 1'b0, 32'h908, '0, 32'hC2, 5, "t5_reload2");

    // Simultaneous read and write is a store (write-allocate)
    push_line(1'b0, 32'h200);
    access(1'b1, 1'b1, 32'h200, 32'h1234_5678, '0, 5, "t6_rdwr");
    access(1'b1, 1'b0, 32'h200, '0, 32'h1234_5678, 0, "t6_load");
    access(1'b1, 1'b0, 32'h208, '0, 32'h208 ^ 32'h5A5A_0000, 0, "t6_neighbour");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
